clk_step_ctrl: RTL
==================

CLK_STEP_CTRL -- requirements
Module: clk_step_ctrl

Interface
REQ-001 SHALL have parameter CNT_W, default 21, divider counter width.
REQ-002 SHALL have parameter DEFAULT_DIV, default 192000, divider reload value after reset.
REQ-003 SHALL have port clk  input  1  system clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n  input  1  reset; asynchronous, active-low.
REQ-005 SHALL have port mode  input  2  00 HALT, 01 RUN, 10 STEP, 11 BURST.
REQ-006 SHALL have port step_req  input  1  start request for STEP/BURST, sampled per cycle.
REQ-007 SHALL have port burst_len  input  8  tick count for BURST, sampled at start.
REQ-008 SHALL have port div_load  input  1  load div_value into divider register.
REQ-009 SHALL have port div_value  input  CNT_W  new divider value; period = div_value+1 cycles.
REQ-010 SHALL have port tick  output  1  one-cycle CPU clock-enable pulse.
REQ-011 SHALL have port clk_slow  output  1  square wave, toggles on every tick.
REQ-012 SHALL have port busy  output  1  high whenever state is not IDLE.
REQ-013 SHALL have port state  output  2  00 IDLE, 01 S_RUN, 10 S_STEP, 11 S_BURST.
REQ-014 SHALL have port tick_total  output  32  count of ticks since reset.

Function
REQ-015 Divider register div_reg SHALL hold the period minus one; div_load writes div_value in the same clock edge, in any state.
REQ-016 Counter cnt SHALL be held at 0 in IDLE, increment by 1 per cycle in other states, and reset to 0 on the cycle it equals div_reg.
REQ-017 tick SHALL be high exactly in the cycles where state is not IDLE, cnt==div_reg and div_load is low.
REQ-018 div_load high SHALL clear cnt to 0 and suppress tick that cycle (load wins over tick).
REQ-019 div_value 0 SHALL give a tick every cycle while active.
REQ-020 IDLE: mode RUN -> S_RUN; mode STEP and step_req -> S_STEP; mode BURST, step_req and burst_len!=0 -> S_BURST with remaining=burst_len; otherwise stay.
REQ-021 BURST start with burst_len==0 SHALL be ignored (stay IDLE).
REQ-022 First tick after leaving IDLE SHALL occur in the (div_reg+1)th cycle spent in the new state.
REQ-023 S_RUN: ticks every div_reg+1 cycles; when mode!=RUN, next edge -> IDLE, cnt cleared, partial period discarded, no tick.
REQ-024 S_STEP: on tick -> IDLE; exactly one tick per accepted request.
REQ-025 S_BURST: each tick decrements remaining; tick with remaining==1 -> IDLE; exactly burst_len ticks.
REQ-026 In S_STEP/S_BURST, mode==HALT SHALL abort to IDLE at next edge with no further tick; other mode changes ignored until completion.
REQ-027 step_req while busy SHALL be ignored, not queued.
REQ-028 clk_slow SHALL toggle on each tick and hold otherwise, including across IDLE.
REQ-029 tick_total SHALL increment by 1 per tick, wrapping 0xFFFFFFFF -> 0.

Reset
REQ-030 rst_n low SHALL immediately force state IDLE, cnt 0, remaining 0, div_reg DEFAULT_DIV, tick 0, clk_slow 0, busy 0, tick_total 0.
REQ-031 Reset mid-STEP/BURST SHALL abort with no tick; after release, block stays IDLE until a new start condition.

Verification
REQ-032 Reset, div_load div_value=3, mode RUN for 20 cycles -> ticks at cycles 4,8,12,16,20 in S_RUN; clk_slow toggles 5 times; tick_total=5.
REQ-033 div_reg=2, mode STEP, step_req 1 cycle, second step_req while busy -> one tick 3 cycles after entry, back to IDLE, tick_total=1.
REQ-034 div_reg=1, mode BURST, burst_len=4, step_req -> 4 ticks every 2 cycles, then IDLE; burst_len=0 -> no state change.
REQ-035 BURST burst_len=10, mode HALT after 3rd tick -> IDLE next edge, tick_total=3; rst_n pulse mid-burst -> all outputs to reset values.
REQ-036 RUN div_reg=5, div_load div_value=1 in the cycle cnt==5 -> no tick that cycle, next ticks every 2 cycles; tick_total forced near 0xFFFFFFFF wraps to 0.

Source files
------------

// File: rtl/clk_step_ctrl.sv
// Programmable clock-enable generator for a stepped CPU: free run, single step or burst of N ticks.
// The divider period is div_reg+1 cycles; div_load restarts the period and suppresses that cycle's tick.
//
// state   | meaning
// IDLE    | no ticks; cnt held at 0, waiting for a start condition
// S_RUN   | ticks every div_reg+1 cycles while mode stays RUN
// S_STEP  | emits one tick, then returns to IDLE
// S_BURST | emits `remaining` ticks, then returns to IDLE
module clk_step_ctrl #(
  parameter int CNT_W       = 21,
  parameter int DEFAULT_DIV = 192000
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [1:0]       mode,
  input  logic             step_req,
  input  logic [7:0]       burst_len,
  input  logic             div_load,
  input  logic [CNT_W-1:0] div_value,
  output logic             tick,
  output logic             clk_slow,
  output logic             busy,
  output logic [1:0]       state,
  output logic [31:0]      tick_total
);

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    S_RUN   = 2'b01,
    S_STEP  = 2'b10,
    S_BURST = 2'b11
  } state_t;

  localparam logic [1:0] MODE_HALT  = 2'b00;
  localparam logic [1:0] MODE_RUN   = 2'b01;
  localparam logic [1:0] MODE_STEP  = 2'b10;
  localparam logic [1:0] MODE_BURST = 2'b11;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] div_reg;
  logic [7:0]       remaining_q, remaining_d;
  logic             hit;

  assign hit   = (cnt_q == div_reg);
  assign tick  = (state_q != IDLE) && hit && !div_load;
  assign busy  = (state_q != IDLE);
  assign state = state_q;

  always_comb begin
    state_d     = state_q;
    remaining_d = remaining_q;
    cnt_d       = cnt_q + 1'b1;
    case (state_q)
      IDLE: begin
        if (mode == MODE_RUN) begin
          state_d = S_RUN;
        end else if (mode == MODE_STEP && step_req) begin
          state_d = S_STEP;
        end else if (mode == MODE_BURST && step_req && burst_len != 8'd0) begin
          state_d     = S_BURST;
          remaining_d = burst_len;
        end
      end
      S_RUN: begin
        if (mode != MODE_RUN) state_d = IDLE;
      end
      S_STEP: begin
        if (mode == MODE_HALT || tick) state_d = IDLE;
      end
      S_BURST: begin
        if (mode == MODE_HALT) begin
          state_d     = IDLE;
          remaining_d = 8'd0;
        end else if (tick) begin
          remaining_d = remaining_q - 1'b1;
          if (remaining_q == 8'd1) state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    // Clearing on entry to IDLE makes every new start begin a full period.
    if (div_load || hit || state_q == IDLE || state_d == IDLE) cnt_d = '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      remaining_q <= 8'd0;
      div_reg     <= CNT_W'(DEFAULT_DIV);
      clk_slow    <= 1'b0;
      tick_total  <= 32'd0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      remaining_q <= remaining_d;
      if (div_load) div_reg <= div_value;
      clk_slow    <= clk_slow ^ tick;
      tick_total  <= tick_total + {31'd0, tick};
    end
  end

endmodule
